// File: rtl/nrd_result_collector.sv
// Result collector for the pipelined non-restoring divider: delay-line tracking, result FIFO, credit-based issue_ready.
// Optional DIV_CHECK_EN: carry a/b alongside each divide and flag results that fail quo*b+rem==a, rem<b.
module nrd_result_collector #(
  parameter int W       = 8,
  parameter int LATENCY = 8,
  parameter int DEPTH   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] a_in,
  input  logic [W-2:0] b_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] rem_in,
  output logic         issue_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_quo,
  output logic [W-1:0] out_rem,
  output logic         out_dz,
  output logic         out_err,
  output logic         overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(LATENCY + 1);
  localparam int W2 = 2 * W;

  logic [LATENCY-1:0] valid_sr_reg;
  logic [LATENCY-1:0] dz_sr_reg;
  logic [IW-1:0]      inflight_reg;
  logic [CW-1:0]      count_reg;
  logic [PW-1:0]      wr_ptr_reg;
  logic [PW-1:0]      rd_ptr_reg;
  logic               overflow_reg;

  logic [W-1:0] mem_quo [DEPTH];
  logic [W-1:0] mem_rem [DEPTH];
  logic         mem_dz  [DEPTH];

  logic capture, cap_dz, cap_err, full, pop, push;

  assign capture = valid_sr_reg[LATENCY-1];
  assign cap_dz  = dz_sr_reg[LATENCY-1];
  assign full    = (count_reg == CW'(DEPTH));
  assign pop     = out_valid && out_ready;
  // A pop on the same edge frees the slot the capture needs, so a full FIFO still accepts.
  assign push    = capture && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_sr_reg <= '0;
      dz_sr_reg    <= '0;
    end else begin
      valid_sr_reg[0] <= in_valid;
      dz_sr_reg[0]    <= (b_in == '0);
      for (int i = 1; i < LATENCY; i++) begin
        valid_sr_reg[i] <= valid_sr_reg[i-1];
        dz_sr_reg[i]    <= dz_sr_reg[i-1];
      end
    end
  end

`ifdef DIV_CHECK_EN
  logic [W-1:0] a_sr_reg [LATENCY];
  logic [W-2:0] b_sr_reg [LATENCY];
  logic [W2-1:0] chk_sum;
  logic          mem_err [DEPTH];

  always_ff @(posedge clk) begin
    a_sr_reg[0] <= a_in;
    b_sr_reg[0] <= b_in;
    for (int i = 1; i < LATENCY; i++) begin
      a_sr_reg[i] <= a_sr_reg[i-1];
      b_sr_reg[i] <= b_sr_reg[i-1];
    end
  end

  assign chk_sum = W2'(quo_in) * W2'(b_sr_reg[LATENCY-1]) + W2'(rem_in);
  assign cap_err = !cap_dz &&
                   ((chk_sum != W2'(a_sr_reg[LATENCY-1])) ||
                    (W2'(rem_in) >= W2'(b_sr_reg[LATENCY-1])));

  always_ff @(posedge clk) begin
    if (push) mem_err[wr_ptr_reg] <= cap_err;
  end
  assign out_err = out_valid ? mem_err[rd_ptr_reg] : 1'b0;
`else
  logic unused_a;
  assign unused_a = ^a_in;
  assign cap_err  = 1'b0;
  assign out_err  = cap_err;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_quo[wr_ptr_reg] <= quo_in;
      mem_rem[wr_ptr_reg] <= rem_in;
      mem_dz[wr_ptr_reg]  <= cap_dz;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (in_valid && !capture)
        inflight_reg <= inflight_reg + IW'(1);
      else if (!in_valid && capture)
        inflight_reg <= inflight_reg - IW'(1);

      if (push && !pop)
        count_reg <= count_reg + CW'(1);
      else if (pop && !push)
        count_reg <= count_reg - CW'(1);

      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (capture && !push) overflow_reg <= 1'b1;
    end
  end

  // Credits cover both buffered results and those still inside the divider.
  assign issue_ready = (32'(count_reg) + 32'(inflight_reg)) < 32'(DEPTH);
  assign out_valid   = (count_reg != '0);
  assign out_quo     = out_valid ? mem_quo[rd_ptr_reg] : '0;
  assign out_rem     = out_valid ? mem_rem[rd_ptr_reg] : '0;
  assign out_dz      = out_valid ? mem_dz[rd_ptr_reg]  : 1'b0;
  assign overflow    = overflow_reg;
endmodule
